// File: rtl/fir_mac_sequencer.sv
// Control sequencer for a time-multiplexed single-MAC FIR filter.
// Accepts one sample per handshake, writes it into the circular delay line,
// walks every tap (sample read address, coefficient address, accumulator
// controls), waits for the MAC pipeline to drain, then holds the result
// valid until the downstream stage takes it.
module fir_mac_sequencer #(
  parameter  int NUMBER_OF_TAPS = 64,
  parameter  int MAC_LATENCY    = 2,
  localparam int ADDR_BITS      = $clog2(NUMBER_OF_TAPS)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic                 sample_we,
  output logic [ADDR_BITS-1:0] wr_addr,
  output logic [ADDR_BITS-1:0] rd_addr,
  output logic [ADDR_BITS-1:0] coeff_addr,
  output logic                 acc_clear,
  output logic                 acc_en,
  output logic                 tap_last,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 busy
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_MAC,
    S_DRAIN,
    S_OUTPUT
  } state_e;

  localparam logic [ADDR_BITS-1:0] ADDR_ZERO = '0;
  localparam logic [ADDR_BITS-1:0] ADDR_ONE  = ADDR_BITS'(1);
  localparam logic [ADDR_BITS-1:0] ADDR_LAST = ADDR_BITS'(NUMBER_OF_TAPS - 1);

  // Drain counter runs 0..MAC_LATENCY-1; unused when the MAC has no latency.
  localparam logic [3:0] DRAIN_LAST = (MAC_LATENCY == 0) ? 4'd0 : 4'(MAC_LATENCY - 1);

  state_e                 state_q, state_d;
  logic [ADDR_BITS-1:0]   head_q,  head_d;   // newest-sample slot in the delay line
  logic [ADDR_BITS-1:0]   k_q,     k_d;      // current tap index
  logic [ADDR_BITS-1:0]   rd_q,    rd_d;     // (head - k) mod N, tracked incrementally
  logic [3:0]             cnt_q,   cnt_d;    // drain cycle counter

  // Next-state and output decode for the tap sequencer.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path leaves
    // one unassigned and no latch is inferred.
    state_d    = state_q;
    head_d     = head_q;
    k_d        = k_q;
    rd_d       = rd_q;
    cnt_d      = cnt_q;
    in_ready   = 1'b0;
    busy       = 1'b1;
    out_valid  = 1'b0;
    acc_en     = 1'b0;
    acc_clear  = 1'b0;
    tap_last   = 1'b0;
    coeff_addr = ADDR_ZERO;

    case (state_q)
      S_IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) begin
          state_d = S_MAC;
          k_d     = ADDR_ZERO;
          rd_d    = head_q;       // tap 0 reads the sample written on this edge
        end
      end

      S_MAC: begin
        acc_en     = 1'b1;
        coeff_addr = k_q;
        acc_clear  = (k_q == ADDR_ZERO);
        tap_last   = (k_q == ADDR_LAST);
        if (k_q == ADDR_LAST) begin
          // rd_q is left on the last tap's address so it stays stable until
          // the next sample is accepted.
          k_d     = ADDR_ZERO;
          cnt_d   = 4'd0;
          state_d = (MAC_LATENCY == 0) ? S_OUTPUT : S_DRAIN;
        end else begin
          k_d  = k_q + ADDR_ONE;
          // Explicit wrap so non-power-of-two lengths stay inside 0..N-1.
          rd_d = (rd_q == ADDR_ZERO) ? ADDR_LAST : rd_q - ADDR_ONE;
        end
      end

      S_DRAIN: begin
        if (cnt_q == DRAIN_LAST) begin
          state_d = S_OUTPUT;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end

      S_OUTPUT: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_d = S_IDLE;
          head_d  = (head_q == ADDR_LAST) ? ADDR_ZERO : head_q + ADDR_ONE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // State registers; reset discards any in-flight result.
  always_ff @(posedge clk or negedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (!rst) begin
      state_q <= S_IDLE;
      head_q  <= ADDR_ZERO;
      k_q     <= ADDR_ZERO;
      rd_q    <= ADDR_ZERO;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      k_q     <= k_d;
      rd_q    <= rd_d;
      cnt_q   <= cnt_d;
    end
  end

  assign sample_we = in_valid & in_ready;
  assign wr_addr   = head_q;
  assign rd_addr   = rd_q;

endmodule
